spi_slave_obi_plug_mc: RTL and testbench

SPI_SLAVE_OBI_PLUG_MC -- requirements
Module: spi_slave_obi_plug_mc

---
 rtl/spi_slave_obi_plug_mc_if.sv | 44 ++++
 rtl/spi_slave_obi_plug_mc.sv | 137 +++++++++++++
 tb/tb_spi_slave_obi_plug_mc.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_obi_plug_mc_if.sv
// OBI master port plus SPI-side streaming signals of the SPI slave plug.
// master: plug view, slave: SPI core / OBI fabric view.
interface spi_slave_obi_plug_mc_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            obi_master_req;
  logic            obi_master_gnt;
  logic [AW-1:0]   obi_master_addr;
  logic            obi_master_we;
  logic [DW/8-1:0] obi_master_be;
  logic [DW-1:0]   obi_master_w_data;
  logic            obi_master_r_valid;
  logic            obi_master_r_ready;
  logic [DW-1:0]   obi_master_r_data;
  logic [AW-1:0]   rxtx_addr;
  logic            rxtx_addr_valid;
  logic            start_tx;
  logic            cs;
  logic [DW-1:0]   tx_data;
  logic            tx_valid;
  logic            tx_ready;
  logic [DW-1:0]   rx_data;
  logic            rx_valid;
  logic            rx_ready;

  modport master (
    output obi_master_req, obi_master_addr, obi_master_we,
    output obi_master_be, obi_master_w_data, obi_master_r_ready,
    input  obi_master_gnt, obi_master_r_valid, obi_master_r_data,
    input  rxtx_addr, rxtx_addr_valid, start_tx, cs,
    output tx_data, tx_valid, rx_ready,
    input  tx_ready, rx_data, rx_valid
  );

  modport slave (
    input  obi_master_req, obi_master_addr, obi_master_we,
    input  obi_master_be, obi_master_w_data, obi_master_r_ready,
    output obi_master_gnt, obi_master_r_valid, obi_master_r_data,
    output rxtx_addr, rxtx_addr_valid, start_tx, cs,
    input  tx_data, tx_valid, rx_ready,
    output tx_ready, rx_data, rx_valid
  );
endinterface

// File: rtl/spi_slave_obi_plug_mc.sv
// SPI slave to OBI bridge: single-outstanding OBI master with
// write buffer and a flushable read-prefetch FIFO.
module spi_slave_obi_plug_mc #(
  parameter int OBI_ADDR_WIDTH = 32,
  parameter int OBI_DATA_WIDTH = 32,
  parameter int PREFETCH_DEPTH = 2,
  parameter int ADDR_INCR_EN   = 1
) (
  input logic obi_aclk,
  input logic obi_aresetn,
  spi_slave_obi_plug_mc_if.master bus
);
  localparam int AW = OBI_ADDR_WIDTH;
  localparam int DW = OBI_DATA_WIDTH;
  localparam int PW = $clog2(PREFETCH_DEPTH);
  localparam logic [AW-1:0] INC = AW'(DW / 8);
  localparam logic [PW:0] FULL = (PW + 1)'(PREFETCH_DEPTH);

  typedef enum logic [2:0] {
    IDLE, WADDR, WRESP, RADDR, RRESP
  } state_t;

  state_t        r_state;
  logic          r_req;
  logic          r_we;
  logic          r_sess;
  logic          r_disc;
  logic [AW-1:0] r_ptr;
  logic [DW-1:0] r_wbuf;
  logic [DW-1:0] r_mem [PREFETCH_DEPTH];
  logic [PW-1:0] r_wp;
  logic [PW-1:0] r_rp;
  logic [PW:0]   r_cnt;

  logic w_gnt;
  logic w_resp;
  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_rd_ok;

  assign w_gnt   = r_req & bus.obi_master_gnt;
  assign w_resp  = (r_state == WRESP) || (r_state == RRESP);
  assign w_full  = (r_cnt == FULL);
  assign w_empty = (r_cnt == '0);
  assign w_push  = (r_state == RRESP) & bus.obi_master_r_valid
                 & ~r_disc & ~bus.cs;
  assign w_pop   = ~w_empty & bus.tx_ready;
  assign w_rd_ok = r_sess & ~bus.cs & ~w_full;

  assign bus.obi_master_req    = r_req;
  assign bus.obi_master_addr   = r_ptr;
  assign bus.obi_master_we     = r_we;
  assign bus.obi_master_be     = '1;
  assign bus.obi_master_w_data = r_wbuf;
  assign bus.obi_master_r_ready = w_resp & bus.obi_master_r_valid;
  assign bus.rx_ready = (r_state == IDLE) & bus.rx_valid & obi_aresetn;
  assign bus.tx_valid = ~w_empty;
  assign bus.tx_data  = r_mem[r_rp];

  always_ff @(posedge obi_aclk or negedge obi_aresetn) begin
    if (!obi_aresetn) begin
      r_state <= IDLE;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_disc  <= 1'b0;
      r_wbuf  <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.rx_valid) begin
            r_wbuf  <= bus.rx_data;
            r_state <= WADDR;
            r_req   <= 1'b1;
            r_we    <= 1'b1;
          end else if (w_rd_ok) begin
            r_state <= RADDR;
            r_req   <= 1'b1;
            r_we    <= 1'b0;
            r_disc  <= 1'b0;
          end
        end
        WADDR: if (bus.obi_master_gnt) begin
          r_state <= WRESP;
          r_req   <= 1'b0;
          r_we    <= 1'b0;
        end
        RADDR: if (bus.obi_master_gnt) begin
          r_state <= RRESP;
          r_req   <= 1'b0;
        end
        WRESP, RRESP: if (bus.obi_master_r_valid) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
      // deselect while a read is in flight turns its data stale
      if (bus.cs && (r_state == RADDR || r_state == RRESP))
        r_disc <= 1'b1;
    end
  end

  always_ff @(posedge obi_aclk or negedge obi_aresetn) begin
    if (!obi_aresetn) begin
      r_ptr  <= '0;
      r_sess <= 1'b0;
    end else begin
      if (bus.rxtx_addr_valid)
        r_ptr <= bus.rxtx_addr;
      else if (ADDR_INCR_EN != 0 && w_gnt)
        r_ptr <= r_ptr + INC;
      if (bus.cs)
        r_sess <= 1'b0;
      else if (bus.start_tx)
        r_sess <= 1'b1;
    end
  end

  always_ff @(posedge obi_aclk or negedge obi_aresetn) begin
    if (!obi_aresetn) begin
      for (int i = 0; i < PREFETCH_DEPTH; i++) r_mem[i] <= '0;
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else if (bus.cs) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= bus.obi_master_r_data;
        r_wp        <= r_wp + 1'b1;
      end
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + (PW + 1)'(w_push) - (PW + 1)'(w_pop);
    end
  end
endmodule

// File: tb/tb_spi_slave_obi_plug_mc.sv
// Directed bench for the SPI slave OBI plug.
// Inputs change on negedge; outputs are sampled #1 after negedge.
module tb_spi_slave_obi_plug_mc;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  spi_slave_obi_plug_mc_if #(.AW(32), .DW(32)) bus ();

  spi_slave_obi_plug_mc #(
    .OBI_ADDR_WIDTH(32),
    .OBI_DATA_WIDTH(32),
    .PREFETCH_DEPTH(2),
    .ADDR_INCR_EN(1)
  ) dut (
    .obi_aclk(clk),
    .obi_aresetn(rst_n),
    .bus(bus)
  );

  task automatic step;
    @(negedge clk);
  endtask

  task automatic load(input logic [31:0] a);
    bus.rxtx_addr = a;
    bus.rxtx_addr_valid = 1'b1;
    step();
    bus.rxtx_addr_valid = 1'b0;
  endtask

  // OBI responder: waits for req, grants after dly cycles, responds next cycle
  task automatic serve(input int dly, input logic [31:0] rd,
                       output logic [31:0] a, output logic w,
                       output logic [31:0] d, output bit ok);
    ok = 1'b0; a = '0; w = 1'b0; d = '0;
    for (int i = 0; i < 30; i++) begin
      #1;
      if (bus.obi_master_req === 1'b1) begin ok = 1'b1; break; end
      step();
    end
    if (!ok) return;
    a = bus.obi_master_addr;
    w = bus.obi_master_we;
    d = bus.obi_master_w_data;
    repeat (dly) step();
    bus.obi_master_gnt = 1'b1;
    step();
    bus.obi_master_gnt = 1'b0;
    bus.obi_master_r_valid = 1'b1;
    bus.obi_master_r_data = rd;
    step();
    bus.obi_master_r_valid = 1'b0;
  endtask

  task automatic test_reset;
    step(); step(); #1;
    total++; if (bus.obi_master_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b want=0", bus.obi_master_req); end
    total++; if (bus.obi_master_we !== 1'b0) begin bad++; $display("FAIL rst_we got=%b want=0", bus.obi_master_we); end
    total++; if (bus.obi_master_r_ready !== 1'b0) begin bad++; $display("FAIL rst_rready got=%b want=0", bus.obi_master_r_ready); end
    total++; if (bus.rx_ready !== 1'b0) begin bad++; $display("FAIL rst_rxready got=%b want=0", bus.rx_ready); end
    total++; if (bus.tx_valid !== 1'b0) begin bad++; $display("FAIL rst_txvalid got=%b want=0", bus.tx_valid); end
    total++; if (bus.obi_master_be !== 4'hF) begin bad++; $display("FAIL rst_be got=%h want=f", bus.obi_master_be); end
    total++; if (bus.obi_master_addr !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h want=0", bus.obi_master_addr); end
    total++; if (bus.obi_master_w_data !== 32'h0) begin bad++; $display("FAIL rst_wdata got=%h want=0", bus.obi_master_w_data); end
    total++; if (bus.tx_data !== 32'h0) begin bad++; $display("FAIL rst_txdata got=%h want=0", bus.tx_data); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_write;
    logic [31:0] a, d;
    logic w;
    bit ok;
    load(32'h1000);
    bus.rx_data = 32'hDEADBEEF;
    bus.rx_valid = 1'b1;
    #1;
    total++; if (bus.rx_ready !== 1'b1) begin bad++; $display("FAIL wr_rxready got=%b want=1", bus.rx_ready); end
    step();
    bus.rx_valid = 1'b0;
    #1;
    total++; if (bus.rx_ready !== 1'b0) begin bad++; $display("FAIL wr_rxready_busy got=%b want=0", bus.rx_ready); end
    serve(2, 32'h0, a, w, d, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL wr1_timeout got=%b want=1", ok); end
    total++; if (a !== 32'h1000) begin bad++; $display("FAIL wr1_addr got=%h want=1000", a); end
    total++; if (w !== 1'b1) begin bad++; $display("FAIL wr1_we got=%b want=1", w); end
    total++; if (d !== 32'hDEADBEEF) begin bad++; $display("FAIL wr1_data got=%h want=deadbeef", d); end
    bus.rx_data = 32'h12345678;
    bus.rx_valid = 1'b1;
    step();
    bus.rx_valid = 1'b0;
    serve(0, 32'h0, a, w, d, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL wr2_timeout got=%b want=1", ok); end
    total++; if (a !== 32'h1004) begin bad++; $display("FAIL wr2_addr got=%h want=1004", a); end
    total++; if (d !== 32'h12345678) begin bad++; $display("FAIL wr2_data got=%h want=12345678", d); end
  endtask

  task automatic test_prefetch;
    logic [31:0] a, d;
    logic w;
    bit ok;
    int reqs;
    bus.tx_ready = 1'b0;
    load(32'h2000);
    bus.cs = 1'b0;
    bus.start_tx = 1'b1;
    step();
    bus.start_tx = 1'b0;
    serve(0, 32'hA0, a, w, d, ok);
    total++; if (ok !== 1'b1 || a !== 32'h2000 || w !== 1'b0) begin bad++; $display("FAIL rd1 got ok=%b addr=%h we=%b want 1/2000/0", ok, a, w); end
    #1;
    total++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== 32'hA0) begin bad++; $display("FAIL rd1_tx got v=%b d=%h want 1/a0", bus.tx_valid, bus.tx_data); end
    serve(1, 32'hA1, a, w, d, ok);
    total++; if (ok !== 1'b1 || a !== 32'h2004 || w !== 1'b0) begin bad++; $display("FAIL rd2 got ok=%b addr=%h we=%b want 1/2004/0", ok, a, w); end
    reqs = 0;
    for (int i = 0; i < 6; i++) begin
      #1; if (bus.obi_master_req === 1'b1) reqs++;
      step();
    end
    total++; if (reqs !== 0) begin bad++; $display("FAIL full_noreq got=%0d want=0", reqs); end
    total++; if (bus.tx_data !== 32'hA0) begin bad++; $display("FAIL head got=%h want=a0", bus.tx_data); end
    bus.tx_ready = 1'b1;
    step();
    bus.tx_ready = 1'b0;
    #1;
    total++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== 32'hA1) begin bad++; $display("FAIL pop got v=%b d=%h want 1/a1", bus.tx_valid, bus.tx_data); end
    serve(0, 32'hA2, a, w, d, ok);
    total++; if (ok !== 1'b1 || a !== 32'h2008) begin bad++; $display("FAIL rd3 got ok=%b addr=%h want 1/2008", ok, a); end
    bus.cs = 1'b1;
    step();
    #1;
    total++; if (bus.tx_valid !== 1'b0) begin bad++; $display("FAIL flush got=%b want=0", bus.tx_valid); end
  endtask

  task automatic test_priority;
    logic [31:0] a, d;
    logic w;
    bit ok;
    load(32'h3000);
    bus.cs = 1'b0;
    bus.start_tx = 1'b1;
    step();
    bus.start_tx = 1'b0;
    bus.rx_data = 32'h55;
    bus.rx_valid = 1'b1;
    #1;
    total++; if (bus.rx_ready !== 1'b1) begin bad++; $display("FAIL prio_rxready got=%b want=1", bus.rx_ready); end
    step();
    bus.rx_valid = 1'b0;
    serve(0, 32'h0, a, w, d, ok);
    total++; if (ok !== 1'b1 || w !== 1'b1 || a !== 32'h3000) begin bad++; $display("FAIL prio_first got ok=%b we=%b addr=%h want 1/1/3000", ok, w, a); end
    serve(0, 32'h66, a, w, d, ok);
    total++; if (ok !== 1'b1 || w !== 1'b0 || a !== 32'h3004) begin bad++; $display("FAIL prio_second got ok=%b we=%b addr=%h want 1/0/3004", ok, w, a); end
    bus.cs = 1'b1;
    step();
    #1;
    total++; if (bus.tx_valid !== 1'b0) begin bad++; $display("FAIL prio_flush got=%b want=0", bus.tx_valid); end
  endtask

  task automatic test_discard;
    bit seen;
    int held;
    int reqs;
    bus.tx_ready = 1'b0;
    load(32'h4000);
    bus.cs = 1'b0;
    bus.start_tx = 1'b1;
    step();
    bus.start_tx = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1; if (bus.obi_master_req === 1'b1) begin seen = 1'b1; break; end
      step();
    end
    total++; if (seen !== 1'b1) begin bad++; $display("FAIL disc_req_timeout got=%b want=1", seen); end
    bus.cs = 1'b1;
    held = 0;
    for (int i = 0; i < 3; i++) begin
      step(); #1;
      if (bus.obi_master_req === 1'b1 && bus.obi_master_addr === 32'h4000) held++;
    end
    total++; if (held !== 3) begin bad++; $display("FAIL disc_hold got=%0d want=3", held); end
    bus.obi_master_gnt = 1'b1;
    step();
    bus.obi_master_gnt = 1'b0;
    bus.obi_master_r_data = 32'hBAD;
    bus.obi_master_r_valid = 1'b1;
    #1;
    total++; if (bus.obi_master_r_ready !== 1'b1) begin bad++; $display("FAIL disc_rready got=%b want=1", bus.obi_master_r_ready); end
    step();
    bus.obi_master_r_valid = 1'b0;
    reqs = 0;
    for (int i = 0; i < 4; i++) begin
      #1; if (bus.tx_valid !== 1'b0 || bus.obi_master_req !== 1'b0) reqs++;
      step();
    end
    total++; if (reqs !== 0) begin bad++; $display("FAIL disc_drop got=%0d want=0", reqs); end
  endtask

  task automatic test_wrap;
    logic [31:0] a, d;
    logic w;
    bit ok;
    bit seen;
    load(32'hFFFFFFFC);
    bus.rx_data = 32'h1;
    bus.rx_valid = 1'b1;
    step();
    bus.rx_valid = 1'b0;
    serve(0, 32'h0, a, w, d, ok);
    total++; if (ok !== 1'b1 || a !== 32'hFFFFFFFC) begin bad++; $display("FAIL wrap1 got ok=%b addr=%h want 1/fffffffc", ok, a); end
    bus.rx_data = 32'h2;
    bus.rx_valid = 1'b1;
    step();
    bus.rx_valid = 1'b0;
    serve(0, 32'h0, a, w, d, ok);
    total++; if (ok !== 1'b1 || a !== 32'h0) begin bad++; $display("FAIL wrap2 got ok=%b addr=%h want 1/0", ok, a); end
    bus.rx_data = 32'h77;
    bus.rx_valid = 1'b1;
    step();
    bus.rx_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1; if (bus.obi_master_req === 1'b1) begin seen = 1'b1; break; end
      step();
    end
    total++; if (seen !== 1'b1 || bus.obi_master_addr !== 32'h4) begin bad++; $display("FAIL wrap3 got req=%b addr=%h want 1/4", seen, bus.obi_master_addr); end
    bus.rxtx_addr = 32'h5000;
    bus.rxtx_addr_valid = 1'b1;
    bus.obi_master_gnt = 1'b1;
    step();
    bus.rxtx_addr_valid = 1'b0;
    bus.obi_master_gnt = 1'b0;
    bus.obi_master_r_valid = 1'b1;
    step();
    bus.obi_master_r_valid = 1'b0;
    #1;
    total++; if (bus.obi_master_addr !== 32'h5000) begin bad++; $display("FAIL load_on_gnt got=%h want=5000", bus.obi_master_addr); end
  endtask

  task automatic test_reset_mid;
    bus.rx_data = 32'h99;
    bus.rx_valid = 1'b1;
    step();
    bus.rx_valid = 1'b0;
    #1;
    total++; if (bus.obi_master_req !== 1'b1) begin bad++; $display("FAIL rm_waddr got=%b want=1", bus.obi_master_req); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (bus.obi_master_req !== 1'b0 || bus.obi_master_we !== 1'b0) begin bad++; $display("FAIL rm_req got req=%b we=%b want 0/0", bus.obi_master_req, bus.obi_master_we); end
    total++; if (bus.obi_master_addr !== 32'h0 || bus.obi_master_w_data !== 32'h0) begin bad++; $display("FAIL rm_regs got addr=%h wd=%h want 0/0", bus.obi_master_addr, bus.obi_master_w_data); end
    total++; if (bus.obi_master_be !== 4'hF || bus.tx_valid !== 1'b0) begin bad++; $display("FAIL rm_misc got be=%h txv=%b want f/0", bus.obi_master_be, bus.tx_valid); end
    step();
    rst_n = 1'b1;
    step(); #1;
    total++; if (bus.obi_master_req !== 1'b0) begin bad++; $display("FAIL rm_after got=%b want=0", bus.obi_master_req); end
  endtask

  initial begin
    bus.obi_master_gnt = 1'b0;
    bus.obi_master_r_valid = 1'b0;
    bus.obi_master_r_data = '0;
    bus.rxtx_addr = '0;
    bus.rxtx_addr_valid = 1'b0;
    bus.start_tx = 1'b0;
    bus.cs = 1'b1;
    bus.tx_ready = 1'b0;
    bus.rx_data = '0;
    bus.rx_valid = 1'b0;
    test_reset();
    test_write();
    test_prefetch();
    test_priority();
    test_discard();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
